// File: rtl/prog_sequence_counter.sv
// prog_sequence_counter
//
// Programmable sequence counter. It steps through a writable table of
// WIDTH-bit codes, so one block can produce binary, Gray, Johnson or any
// custom pattern. After reset the table holds i mod 2^WIDTH, which makes
// the default behaviour a plain binary counter.
//
// Build option:
//   SEQCNT_ONESHOT_EN - when defined, cfg_oneshot (latched on start) makes
//                       a pass end in DONE instead of wrapping. When it is
//                       not defined, cfg_oneshot is ignored and every pass
//                       wraps.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (this also restores the table)
//   start       begin or restart a pass at the first entry
//   stop        go to IDLE and hold dataout/index (stop wins over start)
//   en          step enable while running
//   dir         0 = forward, 1 = reverse; sampled on every step and on start
//   cfg_len     sequence length, latched on start (0 or >DEPTH means DEPTH)
//   cfg_oneshot stop after one pass (used only with SEQCNT_ONESHOT_EN)
//   wr_en       table write strobe; accepted in any state
//   wr_addr     table write index; writes at or above DEPTH are dropped
//   wr_data     table write value
//   dataout     current code (registered)
//   index       table index of dataout
//   wrap        one-cycle pulse while dataout shows the wrapped-to entry
//   busy        high while in RUN
//
// Handshake: there is no valid/ready pairing here. start, stop, en and
// wr_en are single-cycle level strobes sampled on every rising clk edge. A
// step that is sampled on edge N is visible on the outputs after edge N.
module prog_sequence_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         en,
  input  logic                         dir,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
  input  logic                         cfg_oneshot,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH)-1:0]     wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             dataout,
  output logic [$clog2(DEPTH)-1:0]     index,
  output logic                         wrap,
  output logic                         busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH+1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef SEQCNT_ONESHOT_EN
  localparam logic [1:0] ST_DONE = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             wrap_q, wrap_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic [WIDTH-1:0] table_d [DEPTH];

`ifdef SEQCNT_ONESHOT_EN
  logic             oneshot_q, oneshot_d;
`else
  // cfg_oneshot has no function in this build.
  logic             unused_cfg_oneshot;
  assign unused_cfg_oneshot = cfg_oneshot;
`endif

  // Length that start would latch: 0 and anything above DEPTH mean "full table".
  logic [LEN_W-1:0] cfg_len_eff;
  logic [IDX_W-1:0] start_idx;
  // Step helpers, all relative to the length latched for the current pass.
  logic [LEN_W-1:0] len_last;
  logic             at_last;
  logic             at_first;
  logic             step_wrap;
  logic [IDX_W-1:0] step_idx;
  logic             wr_ok;

  always_comb begin
    cfg_len_eff = cfg_len;
    if (cfg_len == '0 || cfg_len > LEN_W'(DEPTH)) begin
      cfg_len_eff = LEN_W'(DEPTH);
    end
    start_idx = dir ? IDX_W'(cfg_len_eff - LEN_W'(1)) : '0;

    len_last  = len_q - LEN_W'(1);
    at_last   = (LEN_W'(index_q) == len_last);
    at_first  = (index_q == '0);
    step_wrap = dir ? at_first : at_last;
    if (dir) begin
      step_idx = at_first ? IDX_W'(len_last) : index_q - IDX_W'(1);
    end else begin
      step_idx = at_last ? '0 : index_q + IDX_W'(1);
    end
  end

  // Table write port. The read for a step uses table_q, so a write that
  // lands in the same cycle as a step to that address is seen on the next
  // load and not on this one.
  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_addr} < (IDX_W+1)'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      table_d[i] = table_q[i];
    end
    if (wr_ok) begin
      table_d[wr_addr] = wr_data;
    end
  end

  // Control FSM
  always_comb begin
    state_d   = state_q;
    dataout_d = dataout_q;
    index_d   = index_q;
    wrap_d    = 1'b0;
    len_d     = len_q;
`ifdef SEQCNT_ONESHOT_EN
    oneshot_d = oneshot_q;
`endif

    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      // Start or restart from the first entry. This path never raises wrap.
      state_d   = ST_RUN;
      len_d     = cfg_len_eff;
      index_d   = start_idx;
      dataout_d = table_q[start_idx];
`ifdef SEQCNT_ONESHOT_EN
      oneshot_d = cfg_oneshot;
`endif
    end else if (state_q == ST_RUN && en) begin
`ifdef SEQCNT_ONESHOT_EN
      if (oneshot_q && step_wrap) begin
        // The pass ends on its last entry; that entry stays on dataout.
        state_d = ST_DONE;
        wrap_d  = 1'b1;
      end else begin
        index_d   = step_idx;
        dataout_d = table_q[step_idx];
        wrap_d    = step_wrap;
      end
`else
      index_d   = step_idx;
      dataout_d = table_q[step_idx];
      wrap_d    = step_wrap;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dataout_q <= '0;
      index_q   <= '0;
      wrap_q    <= 1'b0;
      len_q     <= LEN_W'(DEPTH);
`ifdef SEQCNT_ONESHOT_EN
      oneshot_q <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(i);
      end
    end else begin
      state_q   <= state_d;
      dataout_q <= dataout_d;
      index_q   <= index_d;
      wrap_q    <= wrap_d;
      len_q     <= len_d;
`ifdef SEQCNT_ONESHOT_EN
      oneshot_q <= oneshot_d;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign dataout = dataout_q;
  assign index   = index_q;
  assign wrap    = wrap_q;
  assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_sequence_counter.sv
module tb_prog_sequence_counter;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stop, en, dir, cfg_oneshot, wr_en;
  logic [3:0] cfg_len;
  logic [2:0] wr_addr;
  logic [3:0] wr_addr10;
  logic [3:0] wr_data;

  logic [3:0] dataout;
  logic [2:0] index;
  logic       wrap, busy;
  logic [3:0] dataout10;
  logic [3:0] index10;
  logic       wrap10, busy10;

  int checks = 0;
  int failures = 0;

  prog_sequence_counter #(.WIDTH(4), .DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
    .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .dataout(dataout), .index(index),
    .wrap(wrap), .busy(busy)
  );

  prog_sequence_counter #(.WIDTH(4), .DEPTH(10)) u_dut10 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en(en), .dir(dir),
    .cfg_len(cfg_len), .cfg_oneshot(cfg_oneshot), .wr_en(wr_en),
    .wr_addr(wr_addr10), .wr_data(wr_data), .dataout(dataout10), .index(index10),
    .wrap(wrap10), .busy(busy10)
  );

  // Observed outputs packed as {busy, wrap, index, dataout}
  logic [8:0] obs;
  assign obs = {busy, wrap, index, dataout};
  logic [9:0] obs10;
  assign obs10 = {busy10, wrap10, index10, dataout10};

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; dir = 1'b0;
    cfg_len = 4'd0; cfg_oneshot = 1'b0; wr_en = 1'b0; wr_addr = 3'd0;
    wr_addr10 = 4'd0; wr_data = 4'd0;
    tick();
    reset = 1'b0;
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [3:0] data);
    wr_en = 1'b1; wr_addr = addr[2:0]; wr_addr10 = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] len, input logic d);
    cfg_len = len; dir = d; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 9'b0_0_000_0000) begin
      failures++; $display("FAIL reset: got %b expected %b", obs, 9'b0);
    end
    checks++;
    if (obs10 !== 10'b0) begin
      failures++; $display("FAIL reset_d10: got %b expected %b", obs10, 10'b0);
    end
    en = 1'b1;
    tick();
    checks++;
    if (obs !== 9'b0_0_000_0000) begin
      failures++; $display("FAIL idle_hold: got %b expected %b", obs, 9'b0);
    end
    en = 1'b0;
  endtask

  task automatic test_binary_forward();
    logic [2:0] ei;
    logic [8:0] e;
    do_reset();
    en = 1'b1;
    do_start(4'd0, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL bin_start: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      ei = 3'(k % 8);
      e = {1'b1, (k == 8), ei, {1'b0, ei}};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL bin_step%0d: got %b expected %b", k, obs, e);
      end
    end
    do_stop();
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd1, 4'h1}) begin
      failures++; $display("FAIL bin_stop: got %b expected %b", obs, {1'b0, 1'b0, 3'd1, 4'h1});
    end
  endtask

  task automatic test_johnson();
    logic [3:0] jc [8];
    logic [2:0] ri [4];
    logic [2:0] ei;
    logic [8:0] e;
    jc = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    ri = '{3'd2, 3'd1, 3'd0, 3'd7};
    do_reset();
    for (int i = 0; i < 8; i++) write_entry(4'(i), jc[i]);
    en = 1'b1;
    do_start(4'd8, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL john_start: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      ei = 3'(k % 8);
      e = {1'b1, (k == 8), ei, jc[ei]};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL john_fwd%0d: got %b expected %b", k, obs, e);
      end
    end
    // dataout is now 1110; reverse from there.
    dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = {1'b1, (k == 3), ri[k], jc[ri[k]]};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL john_rev%0d: got %b expected %b", k, obs, e);
      end
    end
    do_stop();
    dir = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic       ens [7];
    logic [2:0] ix  [7];
    logic       wr  [7];
    logic [8:0] e;
    ens = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ix  = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    do_start(4'd3, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL len3_start: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    cfg_len = 4'd5;  // must not matter until the next start
    for (int k = 0; k < 7; k++) begin
      en = ens[k];
      tick();
      e = {1'b1, wr[k], ix[k], {1'b0, ix[k]}};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL len3_step%0d: got %b expected %b", k, obs, e);
      end
    end
    do_stop();
  endtask

  task automatic test_reverse();
    logic [2:0] ix [8];
    logic       wr [8];
    logic [8:0] e;
    // Reverse 3,2,1,0,4(wrap),3, then forward 4, 0(wrap) with len=5.
    ix = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd4, 3'd3, 3'd4, 3'd0};
    wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    do_start(4'd5, 1'b1);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd4, 4'h4}) begin
      failures++; $display("FAIL rev_start: got %b expected %b", obs, {1'b1, 1'b0, 3'd4, 4'h4});
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 6) dir = 1'b0;
      tick();
      e = {1'b1, wr[k], ix[k], {1'b0, ix[k]}};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL rev_step%0d: got %b expected %b", k, obs, e);
      end
    end
    do_stop();
  endtask

  task automatic test_start_stop();
    do_reset();
    en = 1'b1;
    do_start(4'd0, 1'b0);
    repeat (5) tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd5, 4'h5}) begin
      failures++; $display("FAIL ss_run5: got %b expected %b", obs, {1'b1, 1'b0, 3'd5, 4'h5});
    end
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd5, 4'h5}) begin
      failures++; $display("FAIL ss_both: got %b expected %b", obs, {1'b0, 1'b0, 3'd5, 4'h5});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd5, 4'h5}) begin
      failures++; $display("FAIL ss_idle_hold: got %b expected %b", obs, {1'b0, 1'b0, 3'd5, 4'h5});
    end
    do_start(4'd0, 1'b0);
    repeat (3) tick();
    // Restart in RUN with a new length: first entry, no wrap.
    do_start(4'd2, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL ss_restart: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    tick();
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 4'h0}) begin
      failures++; $display("FAIL ss_len2_wrap: got %b expected %b", obs, {1'b1, 1'b1, 3'd0, 4'h0});
    end
    tick();
    do_stop();
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd1, 4'h1}) begin
      failures++; $display("FAIL ss_stop: got %b expected %b", obs, {1'b0, 1'b0, 3'd1, 4'h1});
    end
    // Reset mid-run also restores the table.
    do_start(4'd0, 1'b0);
    tick(); tick();
    en = 1'b0;
    write_entry(4'd1, 4'hC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs !== 9'b0) begin
      failures++; $display("FAIL ss_reset_run: got %b expected %b", obs, 9'b0);
    end
    en = 1'b1;
    do_start(4'd0, 1'b0);
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd1, 4'h1}) begin
      failures++; $display("FAIL ss_table_restored: got %b expected %b", obs, {1'b1, 1'b0, 3'd1, 4'h1});
    end
    do_stop();
  endtask

  task automatic test_len_clamp();
    do_reset();
    en = 1'b1;
    do_start(4'd12, 1'b0);
    repeat (7) tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd7, 4'h7}) begin
      failures++; $display("FAIL clamp_last: got %b expected %b", obs, {1'b1, 1'b0, 3'd7, 4'h7});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 4'h0}) begin
      failures++; $display("FAIL clamp_wrap: got %b expected %b", obs, {1'b1, 1'b1, 3'd0, 4'h0});
    end
    do_start(4'd1, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL len1_start: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 4'h0}) begin
      failures++; $display("FAIL len1_step: got %b expected %b", obs, {1'b1, 1'b1, 3'd0, 4'h0});
    end
    do_stop();
  endtask

  task automatic test_write_hazard();
    logic [2:0] ix [8];
    logic [3:0] dv [8];
    logic [8:0] e;
    ix = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    dv = '{4'h5, 4'h6, 4'h7, 4'h0, 4'h1, 4'h2, 4'hF, 4'hA};
    do_reset();
    en = 1'b1;
    do_start(4'd0, 1'b0);
    repeat (3) tick();
    // Write the displayed entry while holding.
    en = 1'b0;
    write_entry(4'd3, 4'hF);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd3, 4'h3}) begin
      failures++; $display("FAIL wr_displayed: got %b expected %b", obs, {1'b1, 1'b0, 3'd3, 4'h3});
    end
    // Write the entry that this very step loads.
    en = 1'b1;
    write_entry(4'd4, 4'hA);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd4, 4'h4}) begin
      failures++; $display("FAIL wr_same_cycle: got %b expected %b", obs, {1'b1, 1'b0, 3'd4, 4'h4});
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      e = {1'b1, (k == 3), ix[k], dv[k]};
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL wr_pass%0d: got %b expected %b", k, obs, e);
      end
    end
    do_stop();
  endtask

  task automatic test_oneshot();
    do_reset();
    en = 1'b1;
    cfg_oneshot = 1'b1;
    do_start(4'd4, 1'b0);
    repeat (3) tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd3, 4'h3}) begin
      failures++; $display("FAIL os_last: got %b expected %b", obs, {1'b1, 1'b0, 3'd3, 4'h3});
    end
    tick();
`ifdef SEQCNT_ONESHOT_EN
    checks++;
    if (obs !== {1'b0, 1'b1, 3'd3, 4'h3}) begin
      failures++; $display("FAIL os_done: got %b expected %b", obs, {1'b0, 1'b1, 3'd3, 4'h3});
    end
    tick();
    checks++;
    if (obs !== {1'b0, 1'b0, 3'd3, 4'h3}) begin
      failures++; $display("FAIL os_done_hold: got %b expected %b", obs, {1'b0, 1'b0, 3'd3, 4'h3});
    end
`else
    checks++;
    if (obs !== {1'b1, 1'b1, 3'd0, 4'h0}) begin
      failures++; $display("FAIL os_wrap: got %b expected %b", obs, {1'b1, 1'b1, 3'd0, 4'h0});
    end
    tick();
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd1, 4'h1}) begin
      failures++; $display("FAIL os_after_wrap: got %b expected %b", obs, {1'b1, 1'b0, 3'd1, 4'h1});
    end
`endif
    do_start(4'd4, 1'b0);
    checks++;
    if (obs !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
      failures++; $display("FAIL os_restart: got %b expected %b", obs, {1'b1, 1'b0, 3'd0, 4'h0});
    end
    cfg_oneshot = 1'b0;
    do_stop();
  endtask

  task automatic test_depth10();
    logic [3:0] ei;
    logic [9:0] e;
    do_reset();
    write_entry(4'd9, 4'hA);
    write_entry(4'd12, 4'hF);
    en = 1'b1;
    do_start(4'd0, 1'b0);
    checks++;
    if (obs10 !== {1'b1, 1'b0, 4'd0, 4'h0}) begin
      failures++; $display("FAIL d10_start: got %b expected %b", obs10, {1'b1, 1'b0, 4'd0, 4'h0});
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      ei = 4'(k % 10);
      e = {1'b1, (k == 10), ei, (ei == 4'd9) ? 4'hA : ei};
      checks++;
      if (obs10 !== e) begin
        failures++; $display("FAIL d10_step%0d: got %b expected %b", k, obs10, e);
      end
    end
    do_stop();
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_binary_forward();
    test_johnson();
    test_en_toggle();
    test_reverse();
    test_start_stop();
    test_len_clamp();
    test_write_hazard();
    test_oneshot();
    test_depth10();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
